// File: rtl/axi_burst_master.sv
// rtl/axi_burst_master.sv - single-outstanding AXI4 INCR burst master fed by command and beat streams
module axi_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int AXI_ID     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [STRB_WIDTH-1:0] wr_strb,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  done,
    output logic                  done_write,
    output logic [1:0]            done_resp,
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);
    localparam int SIZE = $clog2(STRB_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
    } state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic                  write_q;
    logic [7:0]            beat_cnt;
    logic [1:0]            resp_q;

    logic [ADDR_WIDTH-1:0] cmd_addr_al;
    logic [23:0]           span_end;
    logic                  crosses_4k;
    logic                  at_last;
    logic                  unused_ids;

    // IDs are constant and a single outstanding burst means responses need no matching
    assign unused_ids = ^{m_axi_bid, m_axi_rid};

    // Beat-align the start address and check whether the burst would run past the 4 KB page
    assign cmd_addr_al = cmd_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
    assign span_end    = 24'(cmd_addr_al[11:0]) + (24'({1'b0, cmd_len} + 9'd1) << SIZE);
    assign crosses_4k  = span_end > 24'd4096;
    assign at_last     = (beat_cnt == len_q);

    assign m_axi_awid    = ID_WIDTH'(AXI_ID);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arid    = ID_WIDTH'(AXI_ID);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_wdata   = wr_data;
    assign m_axi_wstrb   = wr_strb;
    assign rd_data       = m_axi_rdata;
    assign done_write    = write_q;
    assign done_resp     = resp_q;

    // State register plus command latch, beat counting and status capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            write_q  <= 1'b0;
            beat_cnt <= '0;
            resp_q   <= 2'b00;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q  <= cmd_addr_al;
                        len_q   <= cmd_len;
                        write_q <= cmd_write;
                        resp_q  <= crosses_4k ? 2'b01 : 2'b00;
                    end
                end
                S_AW: if (m_axi_awready) beat_cnt <= '0;
                S_AR: if (m_axi_arready) beat_cnt <= '0;
                S_W:  if (wr_valid && m_axi_wready) beat_cnt <= beat_cnt + 8'd1;
                S_B:  if (m_axi_bvalid) resp_q <= m_axi_bresp;
                S_R: begin
                    if (m_axi_rvalid && rd_ready) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        // A framing error outranks any slave status; otherwise keep the first error seen
                        if (m_axi_rlast != at_last) begin
                            resp_q <= 2'b01;
                        end else if (resp_q == 2'b00) begin
                            resp_q <= m_axi_rresp;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and handshake decode; data channels are pure pass-through in W and R
    always_comb begin
        state_next    = state;
        cmd_ready     = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        wr_ready      = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_rready  = 1'b0;
        rd_valid      = 1'b0;
        rd_last       = 1'b0;
        done          = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (crosses_4k)     state_next = S_DONE;
                    else if (cmd_write) state_next = S_AW;
                    else                state_next = S_AR;
                end
            end
            S_AW: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) state_next = S_W;
            end
            S_W: begin
                m_axi_wvalid = wr_valid;
                wr_ready     = m_axi_wready;
                m_axi_wlast  = at_last;
                if (wr_valid && m_axi_wready && at_last) state_next = S_B;
            end
            S_B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) state_next = S_DONE;
            end
            S_AR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_next = S_R;
            end
            S_R: begin
                rd_valid     = m_axi_rvalid;
                m_axi_rready = rd_ready;
                rd_last      = at_last;
                if (m_axi_rvalid && rd_ready && (at_last || m_axi_rlast)) state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_burst_master.sv
// tb/tb_axi_burst_master.sv - self-checking bench for axi_burst_master with a behavioural AXI4 RAM slave
module tb_axi_burst_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_last, rd_valid, rd_ready;
    logic        done, done_write;
    logic [1:0]  done_resp;
    logic [7:0]  m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
    logic [15:0] m_axi_awaddr, m_axi_araddr;
    logic [7:0]  m_axi_awlen, m_axi_arlen;
    logic [2:0]  m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
    logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
    logic        m_axi_awlock, m_axi_arlock;
    logic [3:0]  m_axi_awcache, m_axi_arcache;
    logic        m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_wdata, m_axi_rdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

    always #5 clk = ~clk;

    axi_burst_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .done_write(done_write), .done_resp(done_resp),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    typedef struct {
        bit          write;
        logic [15:0] addr;
        logic [7:0]  len;
        bit          toggle;
        logic [1:0]  bresp;
        int          stall_at;
        int          err_beat;
        logic [1:0]  err_val;
        int          err2_beat;
        logic [1:0]  err2_val;
        int          early;
        bit          no_last;
        logic [1:0]  exp_resp;
        bit          over4k;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } beat_t;

    int n_cmp = 0;
    int n_bad = 0;

    beat_t       src_q[$];
    beat_t       wexp[$];
    beat_t       rexp[$];
    logic [31:0] smem    [0:16383];
    logic [31:0] ref_mem [0:16383];

    bit          k_toggle;
    logic [1:0]  k_bresp, k_err_val, k_err2_val;
    int          k_err_beat, k_err2_beat, k_early, k_stall_at;
    bit          k_no_last;
    logic [15:0] k_exp_addr;
    logic [7:0]  k_exp_len;

    int w_got, rd_got, aw_cnt, ar_cnt, bus_cycles;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t v_wr(input logic [15:0] a, input int l, input bit tg,
                                  input logic [1:0] br, input logic [1:0] er, input bit ov);
        vec_t v;
        v.write = 1'b1; v.addr = a; v.len = 8'(l); v.toggle = tg; v.bresp = br;
        v.stall_at = -1; v.err_beat = -1; v.err_val = 2'b00; v.err2_beat = -1; v.err2_val = 2'b00;
        v.early = -1; v.no_last = 1'b0; v.exp_resp = er; v.over4k = ov;
        return v;
    endfunction

    function automatic vec_t v_rd(input logic [15:0] a, input int l, input int st,
                                  input int eb, input logic [1:0] ev, input int eb2, input logic [1:0] ev2,
                                  input int el, input bit nl, input logic [1:0] er, input bit ov);
        vec_t v;
        v.write = 1'b0; v.addr = a; v.len = 8'(l); v.toggle = 1'b0; v.bresp = 2'b00;
        v.stall_at = st; v.err_beat = eb; v.err_val = ev; v.err2_beat = eb2; v.err2_val = ev2;
        v.early = el; v.no_last = nl; v.exp_resp = er; v.over4k = ov;
        return v;
    endfunction

    // Behavioural slave, write-stream source and read-stream sink with scoreboard compares
    initial begin : bus_model
        int          wb, rb, s_rlen, s_wlen, stall_left;
        bit          b_pend, r_act, r_hs;
        logic [15:0] s_waddr, s_raddr;
        beat_t       e;
        int          idx;
        wb = 0; rb = 0; s_rlen = 0; s_wlen = 0; stall_left = 0;
        b_pend = 0; r_act = 0; r_hs = 0; s_waddr = '0; s_raddr = '0;
        for (int i = 0; i < 16384; i++) begin smem[i] = '0; ref_mem[i] = '0; end
        m_axi_awready = 0; m_axi_arready = 0; m_axi_wready = 0;
        m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 0;
        m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 0; m_axi_rvalid = 0;
        wr_valid = 0; wr_data = '0; wr_strb = '0; rd_ready = 0;
        forever begin
            @(negedge clk);
            r_hs = 0;
            if (rst) begin
                src_q.delete(); wexp.delete(); rexp.delete();
                b_pend = 0; r_act = 0; stall_left = 0; wb = 0; rb = 0;
            end else begin
                if (m_axi_awvalid || m_axi_arvalid || m_axi_wvalid || m_axi_bready || m_axi_rready)
                    bus_cycles++;
                if (m_axi_awvalid && m_axi_awready) begin
                    check("awaddr", m_axi_awaddr, k_exp_addr);
                    check("awlen", m_axi_awlen, k_exp_len);
                    s_waddr = m_axi_awaddr; s_wlen = int'(m_axi_awlen); wb = 0; aw_cnt++;
                end
                if (m_axi_wvalid && m_axi_wready) begin
                    if (wexp.size() != 0) begin
                        e = wexp.pop_front();
                        check("w_beat", {m_axi_wdata, m_axi_wstrb, m_axi_wlast}, {e.data, e.strb, e.last});
                    end
                    idx = int'(s_waddr[15:2]) + wb;
                    for (int b = 0; b < 4; b++)
                        if (m_axi_wstrb[b]) smem[idx[13:0]][8*b +: 8] = m_axi_wdata[8*b +: 8];
                    wb++; w_got++;
                    if (wb == s_wlen + 1) b_pend = 1;
                end
                if (wr_valid && wr_ready && src_q.size() != 0) void'(src_q.pop_front());
                if (m_axi_bvalid && m_axi_bready) b_pend = 0;
                if (m_axi_arvalid && m_axi_arready) begin
                    check("araddr", m_axi_araddr, k_exp_addr);
                    check("arlen", m_axi_arlen, k_exp_len);
                    s_raddr = m_axi_araddr; s_rlen = int'(m_axi_arlen); rb = 0; r_act = 1; ar_cnt++;
                end
                if (m_axi_rvalid && m_axi_rready) begin
                    r_hs = 1;
                    if (m_axi_rlast || rb == s_rlen) r_act = 0;
                    rb++;
                end
                if (rd_valid && rd_ready) begin
                    if (rexp.size() != 0) begin
                        e = rexp.pop_front();
                        check("rd_beat", {rd_data, rd_last}, {e.data, e.last});
                    end
                    rd_got++;
                    if (rd_got == k_stall_at) stall_left = 2;
                end
            end
            @(posedge clk);
            #1;
            if (rst) begin
                m_axi_awready = 0; m_axi_arready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
                m_axi_rvalid = 0; m_axi_rlast = 0; wr_valid = 0; rd_ready = 0;
            end else begin
                m_axi_awready = 1'($urandom_range(0, 1));
                m_axi_arready = 1'($urandom_range(0, 1));
                m_axi_wready  = k_toggle ? !m_axi_wready : 1'b1;
                m_axi_bvalid  = b_pend;
                m_axi_bresp   = b_pend ? k_bresp : 2'b00;
                if (!(m_axi_rvalid && !r_hs)) begin
                    if (r_act && $urandom_range(0, 3) != 0) begin
                        idx = int'(s_raddr[15:2]) + rb;
                        m_axi_rvalid = 1;
                        m_axi_rdata  = smem[idx[13:0]];
                        m_axi_rresp  = (rb == k_err_beat) ? k_err_val : (rb == k_err2_beat) ? k_err2_val : 2'b00;
                        m_axi_rlast  = (k_early >= 0) ? (rb == k_early) : (!k_no_last && rb == s_rlen);
                    end else begin
                        m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 2'b00;
                    end
                end
                rd_ready = (stall_left == 0);
                if (stall_left > 0) stall_left--;
                wr_valid = (src_q.size() != 0);
                if (wr_valid) begin wr_data = src_q[0].data; wr_strb = src_q[0].strb; end
            end
        end
    end

    task automatic issue_cmd(input bit wr, input logic [15:0] a, input logic [7:0] l);
        bit seen;
        @(posedge clk); #1;
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = cmd_ready; end
        check("cmd_accept", seen, 1);
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic run_vec(input vec_t v);
        int          lat, nb, nr;
        bit          seen;
        logic [15:0] al;
        logic [31:0] d;
        beat_t       e;
        al = v.addr & 16'hFFFC;
        nb = int'(v.len) + 1;
        nr = (v.early >= 0) ? v.early + 1 : nb;
        k_toggle = v.toggle; k_bresp = v.bresp; k_stall_at = v.stall_at;
        k_err_beat = v.err_beat; k_err_val = v.err_val; k_err2_beat = v.err2_beat; k_err2_val = v.err2_val;
        k_early = v.early; k_no_last = v.no_last; k_exp_addr = al; k_exp_len = v.len;
        w_got = 0; rd_got = 0; aw_cnt = 0; ar_cnt = 0; bus_cycles = 0;
        if (v.write) begin
            for (int k = 0; k < nb; k++) begin
                d = (al == 16'h0100) ? 32'(k + 1) * 32'h1111_1111 : $urandom;
                e.data = d; e.strb = 4'hF; e.last = (k == int'(v.len));
                src_q.push_back(e);
                if (!v.over4k) begin
                    wexp.push_back(e);
                    ref_mem[14'(int'(al[15:2]) + k)] = d;
                end
            end
        end else if (!v.over4k) begin
            for (int k = 0; k < nr; k++) begin
                e.data = ref_mem[14'(int'(al[15:2]) + k)]; e.strb = 4'h0; e.last = (k == int'(v.len));
                rexp.push_back(e);
            end
        end
        issue_cmd(v.write, v.addr, v.len);
        lat = 0; seen = 0;
        while (!seen && lat < 4000) begin @(negedge clk); lat++; seen = done; end
        check($sformatf("done_seen@%h", v.addr), seen, 1);
        check($sformatf("done_resp@%h", v.addr), done_resp, v.exp_resp);
        check($sformatf("done_write@%h", v.addr), done_write, v.write);
        if (v.over4k) begin
            check("over4k_latency", lat, 1);
            check("over4k_bus_cycles", bus_cycles, 0);
            check("over4k_beats", w_got + rd_got, 0);
        end else if (v.write) begin
            check("aw_count", aw_cnt, 1);
            check("w_beats", w_got, nb);
        end else begin
            check("ar_count", ar_cnt, 1);
            check("rd_beats", rd_got, nr);
        end
        @(negedge clk);
        check("post_done_idle", {done, cmd_ready}, 2'b01);
        src_q.delete(); wexp.delete(); rexp.delete();
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t  vecs[$];
        beat_t e;
        bit    seen;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        k_toggle = 0; k_bresp = 0; k_stall_at = -1; k_err_beat = -1; k_err_val = 0;
        k_err2_beat = -1; k_err2_val = 0; k_early = -1; k_no_last = 0; k_exp_addr = '0; k_exp_len = '0;
        w_got = 0; rd_got = 0; aw_cnt = 0; ar_cnt = 0; bus_cycles = 0;
        rst = 0;
        #1 rst = 1;
        #2;
        check("reset_valids", {m_axi_awvalid, m_axi_arvalid, m_axi_wvalid, wr_ready,
                               m_axi_bready, m_axi_rready, rd_valid, done}, 8'h00);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_status", {done_write, done_resp}, 3'b000);
        check("const_aw", {m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot},
              {8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
        check("const_ar", {m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot},
              {8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
        #19 rst = 0;
        repeat (2) @(negedge clk);

        vecs.push_back(v_wr(16'h0100, 3,   1, 2'b00, 2'b00, 0));
        vecs.push_back(v_rd(16'h0100, 3,   2, -1, 2'b00, -1, 2'b00, -1, 0, 2'b00, 0));
        vecs.push_back(v_wr(16'h0200, 1,   0, 2'b10, 2'b10, 0));
        vecs.push_back(v_rd(16'h0100, 3,  -1,  1, 2'b11, -1, 2'b00, -1, 0, 2'b11, 0));
        vecs.push_back(v_wr(16'h0FF8, 3,   0, 2'b00, 2'b01, 1));
        vecs.push_back(v_rd(16'h0FF8, 3,  -1, -1, 2'b00, -1, 2'b00, -1, 0, 2'b01, 1));
        vecs.push_back(v_rd(16'h0100, 3,  -1, -1, 2'b00, -1, 2'b00,  1, 0, 2'b01, 0));
        vecs.push_back(v_wr(16'h0FF0, 3,   1, 2'b00, 2'b00, 0));
        vecs.push_back(v_rd(16'h0FF0, 3,  -1, -1, 2'b00, -1, 2'b00, -1, 0, 2'b00, 0));
        vecs.push_back(v_rd(16'h0103, 3,  -1, -1, 2'b00, -1, 2'b00, -1, 0, 2'b00, 0));
        vecs.push_back(v_wr(16'h0400, 0,   1, 2'b00, 2'b00, 0));
        vecs.push_back(v_rd(16'h0400, 0,  -1, -1, 2'b00, -1, 2'b00, -1, 0, 2'b00, 0));
        vecs.push_back(v_rd(16'h0100, 3,  -1, -1, 2'b00, -1, 2'b00, -1, 1, 2'b01, 0));
        vecs.push_back(v_rd(16'h0200, 1,  -1,  0, 2'b10,  1, 2'b11, -1, 0, 2'b10, 0));
        vecs.push_back(v_wr(16'h0000, 255, 0, 2'b00, 2'b00, 0));
        vecs.push_back(v_rd(16'h0000, 255, 100, -1, 2'b00, -1, 2'b00, -1, 0, 2'b00, 0));
        vecs.push_back(v_wr(16'h0F00, 63,  1, 2'b00, 2'b00, 0));
        vecs.push_back(v_rd(16'h0F04, 63, -1, -1, 2'b00, -1, 2'b00, -1, 0, 2'b01, 1));

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Asynchronous reset during the second beat of an 8-beat write
        k_toggle = 0; k_bresp = 0; k_stall_at = -1; k_exp_addr = 16'h0300; k_exp_len = 8'd7;
        w_got = 0;
        for (int k = 0; k < 8; k++) begin
            e.data = $urandom; e.strb = 4'hF; e.last = (k == 7);
            src_q.push_back(e);
            wexp.push_back(e);
        end
        issue_cmd(1'b1, 16'h0300, 8'd7);
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #2;
            seen = (w_got == 1) && m_axi_wvalid;
        end
        check("rst_reached_beat2", seen, 1);
        check("rst_pre_wr_ready", wr_ready, 1);
        rst = 1;
        #1;
        check("rst_async_drop", {m_axi_awvalid, m_axi_arvalid, m_axi_wvalid, wr_ready,
                                 m_axi_bready, m_axi_rready, rd_valid, done}, 8'h00);
        repeat (3) @(negedge clk);
        #2 rst = 0;
        @(negedge clk);
        check("rst_after_release", {done, cmd_ready}, 2'b01);
        run_vec(v_rd(16'h0100, 3, -1, -1, 2'b00, -1, 2'b00, -1, 0, 2'b00, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
